// File: rtl/cbus_share_arbiter.sv
// cbus_share_arbiter: shares one MMU/cbus port between the instruction-fetch
// requester (ireq/iresp) and the data-memory requester (dreq/dresp).
// Latency: one bubble cycle from request to oreq; responses are combinational.
// Backpressure: the non-owner is ignored while busy and must hold its request.
// Grants are non-preemptive and are released on ready && last or owner abort.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   ireq  / iresp      instruction-side request in / response out
//   dreq  / dresp      data-side request in / response out
//   oreq  / oresp      request to the MMU / response from the MMU
//   grant              one-hot owner (bit0 = I, bit1 = D), 2'b00 when idle
//   busy               a transaction is in flight
//
// Build option: CBUS_ARB_RR_EN selects round-robin tie-breaking. Without it,
// ties go to the data side (fixed priority D over I).

package cbus_pkg;

  typedef logic [3:0] cbus_len_t;

  // Burst length encoding: number of beats minus one.
  localparam cbus_len_t MLEN1  = 4'd0;
  localparam cbus_len_t MLEN2  = 4'd1;
  localparam cbus_len_t MLEN4  = 4'd3;
  localparam cbus_len_t MLEN8  = 4'd7;
  localparam cbus_len_t MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module cbus_share_arbiter
  import cbus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireq,
  output cbus_resp_t iresp,
  input  cbus_req_t  dreq,
  output cbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp,
  output logic [1:0] grant,
  output logic       busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic [0:0] state_next;
  logic       sel;        // current owner: 0 = I, 1 = D
  logic       sel_next;
  logic       last_sel;   // owner of the most recently completed transaction
  logic       last_sel_next;
  logic       pick;       // arbitration winner while idle
  logic       any_valid;
  logic       owner_valid;
  logic       done;

  assign any_valid   = ireq.valid | dreq.valid;
  assign owner_valid = sel ? dreq.valid : ireq.valid;
  assign done        = oresp.ready & oresp.last;

`ifdef CBUS_ARB_RR_EN
  // Round-robin: on a tie the side that did not complete last wins; a lone
  // requester always wins.
  always_comb begin
    pick = 1'b0;
    if (ireq.valid && dreq.valid) begin
      pick = ~last_sel;
    end else begin
      pick = dreq.valid;
    end
  end
`else
  // Fixed priority, data side first. last_sel is still tracked so both builds
  // share the same state machine, but nothing consumes it here.
  always_comb begin
    pick = dreq.valid;
  end

  logic unused_last_sel;
  assign unused_last_sel = last_sel;
`endif

  // Next-state logic. Completion takes precedence over an abort seen in the
  // same cycle so the final beat is always credited to last_sel.
  always_comb begin
    state_next    = state;
    sel_next      = sel;
    last_sel_next = last_sel;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_next = BUSY;
          sel_next   = pick;
        end
      end
      BUSY: begin
        if (done) begin
          state_next    = IDLE;
          last_sel_next = sel;
        end else if (!owner_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= 1'b0;
      last_sel <= 1'b1;   // first round-robin tie goes to the instruction side
    end else begin
      state    <= state_next;
      sel      <= sel_next;
      last_sel <= last_sel_next;
    end
  end

  // Outputs are decoded from registered state only, so an asynchronous reset
  // drops oreq.valid and both responses immediately. MMU responses arriving
  // while idle fall through to the zero defaults and are discarded.
  always_comb begin
    oreq  = '0;
    iresp = '0;
    dresp = '0;
    grant = 2'b00;
    busy  = 1'b0;
    if (state == BUSY) begin
      busy = 1'b1;
      if (sel) begin
        oreq  = dreq;
        dresp = oresp;
        grant = 2'b10;
      end else begin
        oreq  = ireq;
        iresp = oresp;
        grant = 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_cbus_share_arbiter.sv
// Directed bench for cbus_share_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further time unit later, well clear of the next edge.

module tb_cbus_share_arbiter;
  import cbus_pkg::*;

`ifdef CBUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [1:0] G_I = 2'b01;
  localparam logic [1:0] G_D = 2'b10;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireq;
  cbus_resp_t iresp;
  cbus_req_t  dreq;
  cbus_resp_t dresp;
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic [1:0] grant;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  cbus_share_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .oreq  (oreq),
    .oresp (oresp),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle with the requests already set up; runs one
  // single-beat transaction and returns in the following IDLE cycle.
  task automatic serve(input string tag, input logic [1:0] exp_g,
                       input logic [31:0] exp_addr, input logic [63:0] d);
    tick();
    chk({tag, "_grant"}, 128'(grant), 128'(exp_g));
    chk({tag, "_addr"}, 128'(oreq.addr), 128'(exp_addr));
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = d;
    #1;
    if (exp_g == G_I) begin
      chk({tag, "_iresp"}, 128'(iresp.data), 128'(d));
      chk({tag, "_dresp0"}, 128'(dresp), 128'd0);
    end else begin
      chk({tag, "_dresp"}, 128'(dresp.data), 128'(d));
      chk({tag, "_iresp0"}, 128'(iresp), 128'd0);
    end
    tick();
    oresp = '0;
    #1;
    chk({tag, "_idle"}, 128'(busy), 128'd0);
  endtask

  initial begin
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
    tick();

    // Reset state
    chk("rst_grant", 128'(grant), 128'd0);
    chk("rst_busy",  128'(busy),  128'd0);
    chk("rst_oreq",  128'(oreq),  128'd0);
    chk("rst_iresp", 128'(iresp), 128'd0);
    chk("rst_dresp", 128'(dresp), 128'd0);
    reset = 1'b0;
    tick();

    // Single I read, response 3 cycles into the grant
    ireq.valid = 1'b1;
    ireq.addr  = 32'h8000_0000;
    ireq.size  = 3'd2;
    #1;
    chk("t1_req_idle", 128'(busy), 128'd0);
    chk("t1_oreq_v0",  128'(oreq.valid), 128'd0);
    tick();
    chk("t1_grant",  128'(grant), 128'(G_I));
    chk("t1_addr",   128'(oreq.addr), 128'h8000_0000);
    chk("t1_oreq_v", 128'(oreq.valid), 128'd1);
    chk("t1_dresp0", 128'(dresp), 128'd0);
    tick();
    tick();
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 64'h1234;
    #1;
    chk("t1_idata",  128'(iresp.data), 128'h1234);
    chk("t1_ilast",  128'(iresp.last), 128'd1);
    chk("t1_dresp1", 128'(dresp), 128'd0);
    tick();
    ireq = '0;      // oresp left asserted: must be dropped while idle
    #1;
    chk("t1_done_idle", 128'(busy), 128'd0);
    chk("idle_drop",    128'(iresp), 128'd0);
    tick();
    chk("idle_stay", 128'(busy), 128'd0);
    oresp = '0;

    // Tie and sustained contention from a fresh reset
    reset = 1'b1;
    #1;
    reset = 1'b0;
    ireq.valid = 1'b1;
    ireq.addr  = 32'h0000_1000;
    dreq.valid = 1'b1;
    dreq.addr  = 32'h0000_2000;
    #1;
    serve("c1", RR ? G_I : G_D, RR ? 32'h1000 : 32'h2000, 64'hA1);
    serve("c2", G_D, 32'h2000, 64'hA2);
    serve("c3", RR ? G_I : G_D, RR ? 32'h1000 : 32'h2000, 64'hA3);
    serve("c4", G_D, 32'h2000, 64'hA4);
    dreq = '0;
    serve("c5", G_I, 32'h1000, 64'hA5);
    ireq = '0;

    // D write burst of four beats, I waiting from the first beat
    dreq.valid    = 1'b1;
    dreq.is_write = 1'b1;
    dreq.addr     = 32'h0000_3000;
    dreq.len      = MLEN4;
    dreq.data     = 64'hCAFE;
    tick();
    chk("b_grant", 128'(grant), 128'(G_D));
    chk("b_len",   128'(oreq.len), 128'(MLEN4));
    chk("b_wr",    128'(oreq.is_write), 128'd1);
    ireq.valid = 1'b1;
    ireq.addr  = 32'h0000_4000;
    for (int b = 1; b <= 4; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = (b == 4);
      oresp.data  = 64'(b);
      #1;
      chk($sformatf("b_beat%0d_grant", b), 128'(grant), 128'(G_D));
      chk($sformatf("b_beat%0d_data", b), 128'(dresp.data), 128'(b));
      chk($sformatf("b_beat%0d_i0", b), 128'(iresp), 128'd0);
      tick();
    end
    oresp = '0;
    #1;
    chk("b_bubble", 128'(grant), 128'd0);
    dreq = '0;
    serve("b_i", G_I, 32'h4000, 64'hB1);
    ireq = '0;

    // Owner I aborts mid-transaction
    ireq.valid = 1'b1;
    ireq.addr  = 32'h0000_5000;
    tick();
    chk("a_grant", 128'(grant), 128'(G_I));
    tick();
    ireq.valid = 1'b0;
    #1;
    chk("a_oreq_v", 128'(oreq.valid), 128'd0);
    chk("a_busy_same", 128'(busy), 128'd1);
    tick();
    chk("a_busy", 128'(busy), 128'd0);
    chk("a_grant0", 128'(grant), 128'd0);
    ireq = '0;

    // Reset while D owns the bus, I pending
    dreq.valid = 1'b1;
    dreq.addr  = 32'h0000_6000;
    tick();
    chk("r_grant_d", 128'(grant), 128'(G_D));
    ireq.valid  = 1'b1;
    ireq.addr   = 32'h0000_7000;
    oresp.ready = 1'b1;
    oresp.data  = 64'hDEAD;
    #1;
    reset = 1'b1;
    #1;
    chk("r_oreq",  128'(oreq),  128'd0);
    chk("r_dresp", 128'(dresp), 128'd0);
    chk("r_grant", 128'(grant), 128'd0);
    chk("r_busy",  128'(busy),  128'd0);
    #1;
    reset = 1'b0;
    dreq  = '0;
    oresp = '0;
    #1;
    chk("r_bubble", 128'(busy), 128'd0);
    serve("r_i", G_I, 32'h7000, 64'hC1);
    ireq = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
